// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetches 16-bit instructions from a synchronous
// ROM, decodes them into the processing-unit control word, resolves jumps and
// flag branches, and runs data-memory loads/stores through a req/ready
// handshake with a timeout that aborts into HALT.
module control_sequencer #(
  parameter int PC_W    = 6,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     instr_in,
  input  logic [3:0]      flags_in,
  input  logic            mem_ready,
  output logic [PC_W-1:0] imem_addr,
  output logic [15:0]     ctrl_word,
  output logic            mem_req,
  output logic            mem_we,
  output logic            halted,
  output logic            err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALU   = 4'h1;
  localparam logic [3:0] OP_SHIFT = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_BRZ   = 4'h6;
  localparam logic [3:0] OP_BRN   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [15:0]      ir;
  logic             ir_load;
  logic [PC_W-1:0]  pc, pc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_nxt;

  logic [3:0]       op;
  logic [5:0]       aux;
  logic [PC_W-1:0]  target;
  logic             unused_flags;

  assign op        = ir[15:12];
  assign aux       = ir[5:0];
  assign target    = PC_W'(aux);
  assign imem_addr = pc;
  // Only Z and N are used for branching; C and V are passed over.
  assign unused_flags = ^flags_in[3:2];

  // Control word for the instruction held in IR, without the load write-back enable.
  function automatic logic [15:0] decode_ctrl(input logic [15:0] ins);
    logic [1:0] rd, ra, rb;
    logic [5:0] ax;
    logic [15:0] cw;
    rd = ins[11:10];
    ra = ins[9:8];
    rb = ins[7:6];
    ax = ins[5:0];
    cw = 16'h0000;
    unique case (ins[15:12])
      OP_ALU:   cw = {ra, rb, rd, 1'b1, ax[4], ax[3:0], 2'b00, 1'b0, 1'b0};
      OP_SHIFT: cw = {ra, rb, rd, 1'b1, ax[4], 4'b0000, ax[1:0], 1'b1, 1'b0};
      OP_LOAD:  cw = {ra, 2'b00, rd, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1};
      OP_STORE: cw = {ra, rb, 2'b00, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0};
      default:  cw = 16'h0000;
    endcase
    return cw;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Program counter, instruction register, wait counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= '0;
      ir  <= 16'h0000;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      pc  <= pc_nxt;
      cnt <= cnt_nxt;
      err <= err_nxt;
      if (ir_load) ir <= instr_in;
    end
  end

  // Next-state logic and Moore outputs (load write-back enable follows mem_ready).
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    err_nxt   = err;
    ir_load   = 1'b0;
    ctrl_word = 16'h0000;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;
    unique case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        ir_load   = 1'b1;
        pc_nxt    = pc + 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        ctrl_word = decode_ctrl(ir);
        state_nxt = S_FETCH;
        case (op)
          OP_LOAD, OP_STORE: begin
            mem_req   = 1'b1;
            mem_we    = (op == OP_STORE);
            cnt_nxt   = '0;
            state_nxt = S_MEM_WAIT;
          end
          OP_JMP: pc_nxt = target;
          OP_BRZ: if (flags_in[0]) pc_nxt = target;
          OP_BRN: if (flags_in[1]) pc_nxt = target;
          OP_HALT: state_nxt = S_HALT;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM_WAIT: begin
        ctrl_word = decode_ctrl(ir);
        mem_req   = 1'b1;
        mem_we    = (op == OP_STORE);
        if (mem_ready) begin
          // Load data is valid this cycle, so the register write lands on this edge.
          if (op == OP_LOAD) ctrl_word[9] = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_FETCH;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_HALT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level reference model that predicts
// every cycle's outputs, directed scenarios with literal expectations, then
// randomized programs with random flags and memory ready timing.
module tb_control_sequencer;

  localparam int PC_W    = 6;
  localparam int TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [15:0]     instr_in;
  logic [3:0]      flags_in = 4'h0;
  logic            mem_ready = 1'b0;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     ctrl_word;
  logic            mem_req, mem_we, halted, err;

  control_sequencer #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .flags_in(flags_in),
    .mem_ready(mem_ready), .imem_addr(imem_addr), .ctrl_word(ctrl_word),
    .mem_req(mem_req), .mem_we(mem_we), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM.
  logic [15:0] rom [0:63];
  always @(posedge clk) instr_in <= rom[imem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [5:0] m_pc;
  bit         m_err, m_halt;

  // Stimulus modes.
  int         ready_pct = 50;
  int         ready_at  = 0;
  bit         use_force = 1'b0;
  logic [3:0] force_fl  = 4'h0;

  // Values captured from the DUT for literal checks.
  logic [15:0] cap_ctrl, cap_exec_ctrl, cap_wait_ctrl, cap_ready_ctrl;
  logic [5:0]  cap_addr, cap_fetch_addr, cap_exec_addr;
  logic        cap_req, cap_halt, cap_err;
  int          req_cycles;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected control word computed from the field definitions by weighting.
  function automatic logic [15:0] ctrl_of(input logic [15:0] ins);
    int rd, ra, rb, ax, v;
    rd = int'(ins[11:10]);
    ra = int'(ins[9:8]);
    rb = int'(ins[7:6]);
    ax = int'(ins[5:0]);
    case (ins[15:12])
      4'h1:    v = ra*16384 + rb*4096 + rd*1024 + 512 + ((ax/16)%2)*256 + (ax%16)*16;
      4'h2:    v = ra*16384 + rb*4096 + rd*1024 + 512 + ((ax/16)%2)*256 + (ax%4)*4 + 2;
      4'h3:    v = ra*16384 + rd*1024 + 1;
      4'h4:    v = ra*16384 + rb*4096;
      default: v = 0;
    endcase
    return 16'(v);
  endfunction

  function automatic logic [3:0] pick_flags();
    return use_force ? force_fl : 4'($urandom);
  endfunction

  function automatic bit pick_ready();
    return ($urandom_range(0, 99) < ready_pct);
  endfunction

  // One clock cycle: drive inputs just after the falling edge, check, move on.
  task automatic cyc(input logic [15:0] ec, input bit er, input bit ew,
                     input logic [3:0] fl, input bit rdy, input string nm);
    flags_in  = fl;
    mem_ready = rdy;
    #1;
    chk({nm, ".addr"},   32'(imem_addr), 32'(m_pc));
    chk({nm, ".ctrl"},   32'(ctrl_word), 32'(ec));
    chk({nm, ".req"},    32'(mem_req),   32'(er));
    if (er) chk({nm, ".we"}, 32'(mem_we), 32'(ew));
    chk({nm, ".halted"}, 32'(halted),    32'(m_halt));
    chk({nm, ".err"},    32'(err),       32'(m_err));
    cap_ctrl = ctrl_word; cap_addr = imem_addr; cap_req = mem_req;
    cap_halt = halted;    cap_err  = err;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    m_pc = '0; m_err = 1'b0; m_halt = 1'b0;
    #1;
    chk("rst.addr",   32'(imem_addr), 32'h0);
    chk("rst.ctrl",   32'(ctrl_word), 32'h0);
    chk("rst.req",    32'(mem_req),   32'h0);
    chk("rst.halted", 32'(halted),    32'h0);
    chk("rst.err",    32'(err),       32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Execute one instruction of the model against the DUT, cycle by cycle.
  // abort_at>0 pulls rst_n low during that MEM_WAIT cycle.
  task automatic run_instr(input int abort_at);
    logic [15:0] ins, ec, ec2;
    logic [3:0]  fl;
    logic [3:0]  op;
    bit          is_mem, rdy;
    req_cycles = 0;
    if (m_halt) begin
      cyc(16'h0, 1'b0, 1'b0, pick_flags(), pick_ready(), "halt");
      return;
    end
    cyc(16'h0, 1'b0, 1'b0, pick_flags(), pick_ready(), "fetch");
    cap_fetch_addr = cap_addr;
    ins = rom[m_pc];
    cyc(16'h0, 1'b0, 1'b0, pick_flags(), pick_ready(), "decode");
    m_pc = m_pc + 6'd1;
    op = ins[15:12];
    ec = ctrl_of(ins);
    is_mem = (op == 4'h3) || (op == 4'h4);
    fl = pick_flags();
    cyc(ec, is_mem, op == 4'h4, fl, pick_ready(), "exec");
    cap_exec_ctrl = cap_ctrl;
    cap_exec_addr = cap_addr;
    if (cap_req) req_cycles++;
    case (op)
      4'h5: m_pc = ins[5:0];
      4'h6: if (fl[0]) m_pc = ins[5:0];
      4'h7: if (fl[1]) m_pc = ins[5:0];
      4'hF: m_halt = 1'b1;
      default: ;
    endcase
    if (is_mem) begin
      for (int k = 1; k <= TIMEOUT; k++) begin
        if (abort_at == k) begin
          mem_ready = 1'b0;
          #1;
          chk("abort.pre_req", 32'(mem_req),   32'h1);
          chk("abort.pre_ctrl", 32'(ctrl_word), 32'(ec));
          rst_n = 1'b0;
          #1;
          chk("abort.req",  32'(mem_req),   32'h0);
          chk("abort.we",   32'(mem_we),    32'h0);
          chk("abort.ctrl", 32'(ctrl_word), 32'h0);
          m_pc = '0; m_err = 1'b0; m_halt = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        rdy = (ready_at > 0) ? (k == ready_at) : pick_ready();
        ec2 = ec | ((op == 4'h3 && rdy) ? 16'h0200 : 16'h0000);
        cyc(ec2, 1'b1, op == 4'h4, pick_flags(), rdy, "memwait");
        if (cap_req) req_cycles++;
        if (rdy) begin
          cap_ready_ctrl = cap_ctrl;
          break;
        end
        cap_wait_ctrl = cap_ctrl;
        if (k == TIMEOUT) begin
          m_err  = 1'b1;
          m_halt = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [15:0] rand_instr();
    int r;
    logic [3:0] op;
    r = $urandom_range(0, 99);
    if      (r < 20) op = 4'h1;
    else if (r < 35) op = 4'h2;
    else if (r < 50) op = 4'h3;
    else if (r < 62) op = 4'h4;
    else if (r < 70) op = 4'h5;
    else if (r < 78) op = 4'h6;
    else if (r < 86) op = 4'h7;
    else if (r < 92) op = 4'h0;
    else if (r < 94) op = 4'hF;
    else             op = 4'($urandom_range(8, 14));
    return {op, 12'($urandom)};
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    @(negedge clk);

    // ALU instruction: literal control word and PC increment.
    chk("model.alu", 32'(ctrl_of(16'h16C3)), 32'hB630);
    rom[0] = 16'h16C3;
    do_reset();
    run_instr(0);
    chk("t1.exec_ctrl", 32'(cap_exec_ctrl), 32'hB630);
    chk("t1.exec_addr", 32'(cap_exec_addr), 32'h1);

    // Load with two not-ready cycles (counted from EXEC), ready on the 2nd wait.
    rom[0] = 16'h3900; rom[1] = 16'h0000;
    ready_at = 2;
    do_reset();
    run_instr(0);
    chk("t2.req_cycles", 32'(req_cycles), 32'd3);
    chk("t2.wait_ctrl",  32'(cap_wait_ctrl), 32'h4801);
    chk("t2.ready_ctrl", 32'(cap_ready_ctrl), 32'h4A01);
    run_instr(0);
    chk("t2.next_fetch", 32'(cap_fetch_addr), 32'h1);
    ready_at = 0;

    // BRZ taken and not taken.
    rom[0] = 16'h602A; rom[1] = 16'h0000; rom[6'h2A] = 16'h0000;
    use_force = 1'b1; force_fl = 4'b0001;
    do_reset();
    run_instr(0); run_instr(0);
    chk("t3.taken", 32'(cap_fetch_addr), 32'h2A);
    force_fl = 4'b0000;
    do_reset();
    run_instr(0); run_instr(0);
    chk("t3.not_taken", 32'(cap_fetch_addr), 32'h1);
    use_force = 1'b0;

    // Load that never completes: timeout into HALT.
    rom[0] = 16'h3900;
    ready_pct = 0;
    do_reset();
    run_instr(0);
    for (int i = 0; i < 3; i++) run_instr(0);
    chk("t4.halted", 32'(cap_halt), 32'h1);
    chk("t4.err",    32'(cap_err),  32'h1);
    chk("t4.req",    32'(cap_req),  32'h0);
    chk("t4.ctrl",   32'(cap_ctrl), 32'h0);
    ready_pct = 50;

    // JMP to the top address, then PC wraps to zero.
    rom[0] = 16'h503F; rom[6'h3F] = 16'h0000;
    do_reset();
    run_instr(0); run_instr(0);
    chk("t5.jmp_fetch", 32'(cap_fetch_addr), 32'h3F);
    chk("t5.wrap",      32'(cap_exec_addr),  32'h0);
    rom[0] = 16'hF000;
    do_reset();
    run_instr(0); run_instr(0); run_instr(0);
    chk("t5.halted", 32'(cap_halt), 32'h1);
    chk("t5.addr",   32'(cap_addr), 32'h1);

    // Asynchronous reset in the 2nd MEM_WAIT cycle of a store.
    rom[0] = 16'h4D80;
    ready_pct = 0;
    do_reset();
    run_instr(2);
    chk("t6.exec_ctrl", 32'(cap_exec_ctrl), 32'h6000);
    rom[0] = 16'h0000;
    run_instr(0);
    chk("t6.restart", 32'(cap_fetch_addr), 32'h0);

    // Randomized programs.
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < 64; i++) rom[i] = rand_instr();
      case (p % 4)
        0: ready_pct = 100;
        1: ready_pct = 50;
        2: ready_pct = 25;
        default: ready_pct = (p % 8 == 7) ? 0 : 60;
      endcase
      do_reset();
      for (int n = 0; n < 25; n++) run_instr(0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
